// File: rtl/sequenciador_pc.sv
// Program-counter sequencer: fetch / wait / update loop, jal link register, halt and resume.
// Optional return stack enabled by defining PILHA_RETORNO_EN.
module sequenciador_pc #(
  parameter int                  LARGURA    = 9,
  parameter logic [LARGURA-1:0]  RESET_PC   = '0,
  parameter int                  PROF_PILHA = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               fim_instr,
  input  logic               on_controle,
  input  logic               jump,
  input  logic [LARGURA-1:0] endout,
  input  logic               jal,
  input  logic               retorno,
  input  logic               halt_req,
  input  logic               retomar,
  output logic [LARGURA-1:0] pc,
  output logic [LARGURA-1:0] pc_mais1,
  output logic               busca,
  output logic [LARGURA-1:0] link,
  output logic               parado,
  output logic [2:0]         estado
);

  typedef enum logic [2:0] {
    INICIO   = 3'd0,
    BUSCA    = 3'd1,
    ESPERA   = 3'd2,
    ATUALIZA = 3'd3,
    PARADO   = 3'd4
  } estado_t;

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] pc_q, link_q, pc_novo_q, pc_novo_d;
  logic               busca_q, busca_d;
  logic               jal_q, halt_q;
  logic               evento_fim;

  assign evento_fim = (estado_q == ESPERA) && fim_instr;
  assign pc_mais1   = pc_q + LARGURA'(1);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) estado_q <= INICIO;
    else       estado_q <= estado_d;
  end

  // Next-state logic.
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      INICIO:   estado_d = BUSCA;
      BUSCA:    if (!stall) estado_d = ESPERA;
      ESPERA:   if (fim_instr) estado_d = ATUALIZA;
      ATUALIZA: estado_d = halt_q ? PARADO : BUSCA;
      PARADO:   if (retomar) estado_d = BUSCA;
      default:  estado_d = INICIO;
    endcase
  end

  // Output logic; the fetch strobe is registered below, so it shows in the cycle after BUSCA.
  always_comb begin
    busca_d = (estado_q == BUSCA) && !stall;
    parado  = (estado_q == PARADO);
  end

`ifdef PILHA_RETORNO_EN
  localparam int CW = $clog2(PROF_PILHA + 1);

  logic [LARGURA-1:0] pilha [PROF_PILHA];
  logic [CW-1:0]      n_pilha;
  logic               pop_ok;
  logic               unused_jump;

  assign unused_jump = jump;
  assign pop_ok      = retorno && (n_pilha != '0);

  always_comb begin
    pc_novo_d = on_controle ? endout : pc_mais1;
    if (pop_ok) pc_novo_d = pilha[0];
  end

  // NOTE: stack storage is not reset; the occupancy counter alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (evento_fim) begin
      if (jal && pop_ok) begin
        pilha[0] <= pc_mais1;
      end else if (jal) begin
        for (int i = PROF_PILHA - 1; i > 0; i--) pilha[i] <= pilha[i-1];
        pilha[0] <= pc_mais1;
      end else if (pop_ok) begin
        for (int i = 0; i < PROF_PILHA - 1; i++) pilha[i] <= pilha[i+1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      n_pilha <= '0;
    end else if (evento_fim) begin
      if (jal && !pop_ok && n_pilha != CW'(PROF_PILHA)) n_pilha <= n_pilha + CW'(1);
      else if (!jal && pop_ok)                          n_pilha <= n_pilha - CW'(1);
    end
  end
`else
  logic unused_entradas;

  assign unused_entradas = jump ^ retorno ^ (PROF_PILHA == 0);
  assign pc_novo_d       = on_controle ? endout : pc_mais1;
`endif

  // Datapath: pending latches captured at fim_instr, committed in ATUALIZA.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      link_q    <= '0;
      busca_q   <= 1'b0;
      pc_novo_q <= '0;
      jal_q     <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      busca_q <= busca_d;
      if (evento_fim) begin
        pc_novo_q <= pc_novo_d;
        jal_q     <= jal;
        halt_q    <= halt_req;
      end
      if (estado_q == ATUALIZA) begin
        pc_q <= pc_novo_q;
        if (jal_q) link_q <= pc_mais1;
      end
    end
  end

  assign pc     = pc_q;
  assign link   = link_q;
  assign busca  = busca_q;
  assign estado = estado_q;

endmodule

// File: tb/tb_sequenciador_pc.sv
// Self-checking bench for sequenciador_pc: directed scenarios plus random stimulus
// compared every cycle against a transaction-level reference model.
module tb_sequenciador_pc;

  localparam int L    = 9;
  localparam int PROF = 4;

  logic         clock = 1'b0;
  logic         reset, stall, fim_instr, on_controle, jump, jal, retorno, halt_req, retomar;
  logic [L-1:0] endout;
  logic [L-1:0] pc, pc_mais1, link;
  logic         busca, parado;
  logic [2:0]   estado;

  int checks = 0;
  int errors = 0;

  sequenciador_pc #(.LARGURA(L), .RESET_PC('0), .PROF_PILHA(PROF)) dut (
    .clock(clock), .reset(reset), .stall(stall), .fim_instr(fim_instr),
    .on_controle(on_controle), .jump(jump), .endout(endout), .jal(jal),
    .retorno(retorno), .halt_req(halt_req), .retomar(retomar),
    .pc(pc), .pc_mais1(pc_mais1), .busca(busca), .link(link),
    .parado(parado), .estado(estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 start, 1 fetch, 2 waiting, 3 commit, 4 halted.
  int           m_fase = 0;
  int           m_pc = 0, m_link = 0, m_novo = 0;
  bit           m_busca = 0, m_jal = 0, m_halt = 0;
  int           m_pilha[$];

  function automatic int inc(input int v);
    return (v + 1) % (1 << L);
  endfunction

  task automatic model_step();
    bit busca_n;
    if (reset) begin
      m_fase = 0; m_pc = 0; m_link = 0; m_busca = 0;
      m_jal = 0; m_halt = 0; m_novo = 0;
      m_pilha.delete();
      return;
    end
    busca_n = (m_fase == 1) && !stall;
    case (m_fase)
      0: m_fase = 1;
      1: if (!stall) m_fase = 2;
      2: if (fim_instr) begin
           m_novo = on_controle ? int'(endout) : inc(m_pc);
`ifdef PILHA_RETORNO_EN
           if (retorno && m_pilha.size() > 0) m_novo = m_pilha.pop_back();
           if (jal) begin
             m_pilha.push_back(inc(m_pc));
             if (m_pilha.size() > PROF) void'(m_pilha.pop_front());
           end
`endif
           m_jal  = jal;
           m_halt = halt_req;
           m_fase = 3;
         end
      3: begin
           if (m_jal) m_link = inc(m_pc);
           m_pc   = m_novo;
           m_fase = m_halt ? 4 : 1;
         end
      4: if (retomar) m_fase = 1;
      default: m_fase = 0;
    endcase
    m_busca = busca_n;
  endtask

  task automatic cyc(input bit rs, input bit st, input bit fi, input bit oc,
                     input logic [L-1:0] eo, input bit jl, input bit rt,
                     input bit hr, input bit rm);
    @(negedge clock);
    reset = rs; stall = st; fim_instr = fi; on_controle = oc; endout = eo;
    jal = jl; retorno = rt; halt_req = hr; retomar = rm; jump = $urandom_range(0, 1);
    @(posedge clock);
    model_step();
    #1;
    check("pc", pc, m_pc);
    check("pc_mais1", pc_mais1, inc(m_pc));
    check("busca", busca, m_busca);
    check("link", link, m_link);
    check("parado", parado, m_fase == 4);
    check("estado", estado, m_fase);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic go_espera();
    for (int i = 0; i < 8 && m_fase != 2; i++) cyc(0, 0, 0, 0, '0, 0, 0, 0, 1);
    check("reach_espera", estado, 3'd2);
  endtask

  // Finish an instruction from ESPERA and let the commit cycle pass.
  task automatic finish(input bit oc, input logic [L-1:0] eo, input bit jl,
                        input bit rt, input bit hr);
    go_espera();
    cyc(0, 0, 1, oc, eo, jl, rt, hr, 0);
    idle();
  endtask

  initial begin
    reset = 1; stall = 0; fim_instr = 0; on_controle = 0; endout = '0;
    jal = 0; retorno = 0; halt_req = 0; retomar = 0; jump = 0;
    cyc(1, 0, 0, 0, '0, 0, 0, 0, 0);
    check("reset_pc", pc, 0);
    check("reset_estado", estado, 0);
    idle();
    check("inicio_to_busca", estado, 1);
    idle();
    check("first_busca", busca, 1);
    check("first_espera", estado, 2);

    finish(1, 9'd5, 0, 0, 0);
    finish(0, 9'd0, 0, 0, 0);
    check("pc_inc", pc, 6);
    idle();
    check("busca_after_update", busca, 1);
    finish(1, 9'd511, 0, 0, 0);
    finish(0, 9'd0, 0, 0, 0);
    check("pc_wrap", pc, 0);

    finish(1, 9'h10, 0, 0, 0);
    finish(1, 9'h40, 1, 0, 0);
    check("jal_pc", pc, 9'h40);
    check("jal_link", link, 9'h11);
    finish(0, 9'h1ff, 1, 0, 0);
    check("jal_seq_link", link, 9'h41);

    repeat (3) begin
      cyc(0, 1, 0, 0, '0, 0, 0, 0, 0);
      check("stall_no_busca", busca, 0);
    end
    check("stall_pc", pc, 9'h41);
    idle();
    check("stall_release", busca, 1);
    idle();
    check("busca_single", busca, 0);

    finish(1, 9'h20, 0, 0, 1);
    check("halt_pc", pc, 9'h20);
    check("halt_parado", parado, 1);
    cyc(0, 0, 1, 1, 9'h55, 0, 0, 0, 0);
    check("halt_holds", pc, 9'h20);
    check("halt_no_busca", busca, 0);
    cyc(0, 0, 0, 0, '0, 0, 0, 0, 1);
    idle();
    check("resume_busca", busca, 1);
    check("resume_pc", pc, 9'h20);
    go_espera();
    cyc(1, 0, 0, 0, '0, 0, 0, 0, 0);
    check("reset_mid_pc", pc, 0);
    check("reset_mid_estado", estado, 0);

`ifdef PILHA_RETORNO_EN
    finish(1, 9'd3, 0, 0, 0);
    finish(1, 9'd7, 1, 0, 0);
    finish(0, 9'd0, 1, 0, 0);
    finish(0, 9'd0, 0, 1, 0);
    check("pilha_ret1", pc, 8);
    finish(0, 9'd0, 0, 1, 0);
    check("pilha_ret2", pc, 4);
    finish(0, 9'd0, 0, 1, 0);
    check("pilha_vazia", pc, 5);
`endif

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) < 4, $urandom_range(0, 1),
          L'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
